// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues single-cycle-latency
// reads to instruction memory and buffers {instr, pc} pairs in a small
// circular FIFO whose head feeds the IF/ID pipeline register.
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       stall_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic                       imem_req_o,
    output logic [31:0]                imem_addr_o,
    input  logic [31:0]                imem_instr_i,
    output logic                       valid_o,
    output logic [31:0]                instr_o,
    output logic [31:0]                pc_o,
    output logic [$clog2(DEPTH):0]     queue_cnt_o
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW:0]     L_DEPTH = (CW + 1)'(DEPTH);

    // architectural state
    logic [31:0]    r_pc;
    logic [31:0]    r_issue_pc;
    logic           r_inflight;
    logic           r_squash;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic [31:0]    r_mem_instr [DEPTH];
    logic [31:0]    r_mem_pc    [DEPTH];

    // combinational control
    logic [CW:0]    w_occ;
    logic           w_space;
    logic           w_req;
    logic           w_valid;
    logic           w_enq;
    logic           w_deq;
    logic [31:0]    w_head_instr;
    logic [31:0]    w_head_pc;

    // Occupancy counts the outstanding response, so an issued request always
    // has a slot waiting for it even if nothing dequeues.
    assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_space = (w_occ < L_DEPTH);
    assign w_valid = (r_count != {CW{1'b0}});
    assign w_enq   = r_inflight & ~r_squash & ~redirect_i;
    assign w_deq   = w_valid & ~stall_i & ~redirect_i;

    // Issue decision; held low while reset is asserted.
    always_comb begin
        w_req = 1'b0;
        if (rst_i && start_i && !redirect_i && w_space) begin
            w_req = 1'b1;
        end else begin
            w_req = 1'b0;
        end
    end

    // Head-entry read, forced to zero when the queue is empty.
    always_comb begin
        w_head_instr = 32'h0000_0000;
        w_head_pc    = 32'h0000_0000;
        if (w_valid) begin
            w_head_instr = r_mem_instr[r_rd_ptr];
            w_head_pc    = r_mem_pc[r_rd_ptr];
        end else begin
            w_head_instr = 32'h0000_0000;
            w_head_pc    = 32'h0000_0000;
        end
    end

    // PC, in-flight and squash tracking; redirect overrides any issue.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc       <= RESET_PC;
            r_issue_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_squash   <= 1'b0;
        end else if (redirect_i) begin
            r_pc       <= {redirect_pc_i[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_squash   <= 1'b1;
        end else begin
            r_squash   <= 1'b0;
            r_inflight <= w_req;
            if (w_req) begin
                r_pc       <= r_pc + 32'd4;
                r_issue_pc <= r_pc;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (redirect_i) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage: the returned word is paired with the PC latched at issue.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= 32'h0000_0000;
                r_mem_pc[i]    <= 32'h0000_0000;
            end
        end else if (w_enq) begin
            r_mem_instr[r_wr_ptr] <= imem_instr_i;
            r_mem_pc[r_wr_ptr]    <= r_issue_pc;
        end
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_pc;
    assign valid_o     = w_valid;
    assign instr_o     = w_head_instr;
    assign pc_o        = w_head_pc;
    assign queue_cnt_o = r_count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed and random stimulus
// compared cycle by cycle against a queue-based reference model.
module tb_if_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [2:0]  queue_cnt_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // reference model state
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_pc;

    if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .queue_cnt_o   (queue_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // imem word k holds k+100
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a >> 2) + 32'd100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_pc      = RESET_PC;
        m_pend    = 1'b0;
        m_pend_pc = 32'h0;
    endtask

    // One clock cycle: drive, check outputs at negedge, advance model at posedge.
    task automatic cycle(input bit st, input bit sl, input bit rd, input logic [31:0] rpc);
        bit          exp_req;
        bit          saw_req;
        logic [31:0] saw_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        start_i       = st;
        stall_i       = sl;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        exp_req   = st && !rd && ((mq.size() + int'(m_pend)) < DEPTH);
        exp_pc    = (mq.size() != 0) ? mq[0].pc    : 32'h0;
        exp_instr = (mq.size() != 0) ? mq[0].instr : 32'h0;
        @(negedge clk_i);
        chk("req",   32'(imem_req_o),  32'(exp_req));
        chk("addr",  imem_addr_o,      m_pc);
        chk("valid", 32'(valid_o),     32'(mq.size() != 0));
        chk("pc",    pc_o,             exp_pc);
        chk("instr", instr_o,          exp_instr);
        chk("cnt",   32'(queue_cnt_o), 32'(mq.size()));
        saw_req  = imem_req_o;
        saw_addr = imem_addr_o;
        @(posedge clk_i);
        if (rd) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc   = rpc & 32'hFFFF_FFFC;
        end else begin
            if (mq.size() != 0 && !sl) void'(mq.pop_front());
            if (m_pend) mq.push_back('{pc: m_pend_pc, instr: word_of(m_pend_pc)});
            if (exp_req) begin
                m_pend    = 1'b1;
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end else begin
                m_pend = 1'b0;
            end
        end
        #1;
        imem_instr_i = saw_req ? word_of(saw_addr) : $urandom();
    endtask

    initial begin
        rst_i         = 1'b0;
        start_i       = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_instr_i  = 32'h0;
        #1;
        // reset state, with start_i already high
        chk("rst_req",   32'(imem_req_o),  32'd0);
        chk("rst_valid", 32'(valid_o),     32'd0);
        chk("rst_pc",    pc_o,             32'd0);
        chk("rst_instr", instr_o,          32'd0);
        chk("rst_cnt",   32'(queue_cnt_o), 32'd0);
        chk("rst_addr",  imem_addr_o,      RESET_PC);
        #1;
        start_i = 1'b0;
        rst_i   = 1'b1;
        m_reset();
        @(posedge clk_i);
        #1;

        // streaming with a stall window that fills the queue
        for (int c = 0; c < 20; c++) cycle(1'b1, (c >= 3 && c <= 9), 1'b0, 32'h0);

        // redirect with requests in flight, misaligned target
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0043);
        for (int c = 0; c < 6; c++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // fill under stall, then redirect while still stalled
        for (int c = 0; c < 6; c++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("full_cnt", 32'(queue_cnt_o), 32'd4);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        for (int c = 0; c < 6; c++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0), $urandom());
        end

        // start drop with 3 queued and 1 in flight
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_1000);
        for (int c = 0; c < 10; c++) begin
            if (!(mq.size() == 3 && m_pend)) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        end
        chk("drop_cnt", 32'(queue_cnt_o), 32'd3);
        for (int c = 0; c < 8; c++) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // reset asserted mid-phase during streaming
        for (int c = 0; c < 5; c++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        rst_i = 1'b0;
        #1;
        chk("mrst_valid", 32'(valid_o),     32'd0);
        chk("mrst_pc",    pc_o,             32'd0);
        chk("mrst_instr", instr_o,          32'd0);
        chk("mrst_cnt",   32'(queue_cnt_o), 32'd0);
        chk("mrst_req",   32'(imem_req_o),  32'd0);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        m_reset();
        @(posedge clk_i);
        #1;
        imem_instr_i = $urandom();
        chk("mrst_addr", imem_addr_o, RESET_PC);
        for (int c = 0; c < 8; c++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register in the 5-stage RISC-V CPU.
- Owns the PC and issues word reads to an instruction memory with fixed 1-cycle latency.
- Buffers returned instructions with their PCs in a small FIFO.
- Presents the head entry to IF/ID, honouring decode stalls (hazard unit) and branch flushes (redirects from ID).

Parameters:
- DEPTH, 4, fetch-queue entries; power of 2, >= 2.
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  fetch enable; no new requests while 0.
- stall_i  in  1  decode stall; head entry held while 1.
- redirect_i  in  1  branch taken/flush from ID; one-cycle pulse.
- redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored (treated as 0).
- imem_req_o  out  1  read request this cycle.
- imem_addr_o  out  32  byte address of request (= PC register).
- imem_instr_i  in  32  read data; valid exactly 1 cycle after a request.
- valid_o  out  1  head entry valid.
- instr_o  out  32  head instruction; 32'b0 when queue empty.
- pc_o  out  32  head PC; 32'b0 when queue empty.
- queue_cnt_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_i=0, immediate, no clock needed):
  - pc <= RESET_PC; queue empty; inflight <= 0; squash <= 0.
  - valid_o=0, instr_o=0, pc_o=0, queue_cnt_o=0, imem_req_o=0.
- State: pc register; inflight flag (1 request outstanding); squash flag; circular FIFO with rd/wr pointers and count.
- Issue condition, combinational: imem_req_o = start_i & ~redirect_i & (count + inflight < DEPTH).
  - Same-cycle dequeue is deliberately ignored, so overflow is impossible.
  - On issue, pc <= pc + 4 (32-bit modular wrap); inflight <= 1. Otherwise inflight <= 0.
- Response: in the cycle after an issue, if inflight & ~squash & ~redirect_i, {imem_instr_i, issued pc} is written at wr pointer.
  - The issued PC is captured in a register at issue time.
- Dequeue: when valid_o & ~stall_i & ~redirect_i, rd pointer advances.
- Same-cycle enqueue and dequeue: count unchanged, both pointers advance.
- Head outputs: valid_o = (count != 0); instr_o and pc_o are read combinationally from the head entry and forced to 0 when empty.
- Latency:
  - Request in cycle N -> data in cycle N+1 -> visible on valid_o/instr_o in N+2 if the queue was empty.
  - Steady-state throughput is 1 instruction/cycle while not stalled.
- Redirect (cycle R), highest priority over stall, enqueue and dequeue:
  - Queue cleared (count <= 0, pointers reset) at end of R.
  - pc <= {redirect_pc_i[31:2], 2'b00}; no request in R.
  - A response arriving in R is dropped. A request issued in R-1 is in flight; squash is set so its response in R is discarded. squash then clears.
  - First request at the new PC in R+1; valid_o with that PC in R+3.
- start_i=0: no issue; an outstanding response still enqueues; the queue drains normally.
- Stall while full: imem_req_o stays 0; entries are neither lost nor duplicated.
- Reset mid-operation discards the in-flight response; the first request after release is at RESET_PC.
- Order guarantee: pc_o sequence out of the queue is strictly pc, pc+4, ... between redirects.

Test Plan:
- Reset, start_i=1 at cycle 0, imem word k = k+100 -> imem_req_o=1 at cycle 0 with addr 0; valid_o=1 at cycle 2 with pc_o=0, instr_o=100; then pc_o 4, 8, 12 on consecutive cycles.
- stall_i=1 for cycles 3-9 -> queue_cnt_o reaches 4 and imem_req_o=0 while full; after release pc_o continues 4, 8, 12, 16, ... with no gap or repeat.
- redirect_i pulse at cycle R with redirect_pc_i=32'h43 while requests are in flight -> queue_cnt_o=0 at R+1; imem_addr_o=0x40 at R+1; valid_o=0 during R+1..R+2; valid_o=1 at R+3 with pc_o=0x40.
- redirect_i=1 and stall_i=1 in the same cycle with a full queue -> flush occurs, queue_cnt_o=0 next cycle; the held instruction is never re-presented.
- rst_i driven low mid-clock-phase during streaming -> valid_o, pc_o, instr_o and queue_cnt_o go to 0 before the next edge; after release, first imem_addr_o=RESET_PC.
- start_i dropped with 3 entries queued and 1 in flight, stall_i=0 -> 4 more instructions emerge in order, then valid_o=0 and imem_req_o stays 0.
